// File: rtl/conv_s2p_lanes_if.sv
// Handshake bundle for conv_s2p_lanes: serial input side and parallel word output side.
// The slave modport is the converter's view; the master modport is the view of whatever drives it.
interface conv_s2p_lanes_if #(
    parameter int WIDTH = 4,
    parameter int LANES = 4
);
    logic                     din;
    logic                     din_valid;
    logic                     din_sof;
    logic                     din_ready;
    logic [WIDTH*LANES-1:0]   dout;
    logic                     dout_valid;
    logic                     dout_ready;
    logic                     frame_err;

    modport master (
        output din, din_valid, din_sof, dout_ready,
        input  din_ready, dout, dout_valid, frame_err
    );

    modport slave (
        input  din, din_valid, din_sof, dout_ready,
        output din_ready, dout, dout_valid, frame_err
    );
endinterface

// File: rtl/conv_s2p_lanes.sv
// Serial-to-parallel converter: collects a 1-bit stream into LANES x WIDTH-bit words.
// A single holding register lets the next word assemble while the previous one waits.
module conv_s2p_lanes #(
    parameter int WIDTH     = 4,
    parameter int LANES     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic            clk,
    input  logic            rst,
    conv_s2p_lanes_if.slave bus
);
    localparam int N  = WIDTH * LANES;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    // The N-th bit of a word comes straight from din, so only N-1 bits need storing.
    logic [N-2:0]  sr_r;
    logic [N-2:0]  sr_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic [N-1:0]  dout_r;
    logic [N-1:0]  dout_nxt_s;
    logic [N-1:0]  word_s;
    logic          dout_valid_r;
    logic          dout_valid_nxt_s;
    logic          frame_err_r;
    logic          frame_err_nxt_s;
    logic          ready_s;
    logic          accept_s;

    // Input readiness, word formation and next state of counter, shifter and holding register
    always_comb begin
        sr_nxt_s         = sr_r;
        cnt_nxt_s        = cnt_r;
        dout_nxt_s       = dout_r;
        dout_valid_nxt_s = dout_valid_r;
        frame_err_nxt_s  = 1'b0;

        ready_s  = !((cnt_r == CNT_LAST) && dout_valid_r && !bus.dout_ready);
        accept_s = bus.din_valid && ready_s;

        if (MSB_FIRST != 0) begin
            word_s = {sr_r, bus.din};
        end else begin
            word_s = {bus.din, sr_r};
        end

        if (dout_valid_r && bus.dout_ready) begin
            dout_valid_nxt_s = 1'b0;
        end else begin
            dout_valid_nxt_s = dout_valid_r;
        end

        if (accept_s) begin
            if (MSB_FIRST != 0) begin
                sr_nxt_s = word_s[N-2:0];
            end else begin
                sr_nxt_s = word_s[N-1:1];
            end

            // Start-of-frame wins over completion; stale partial bits age out of the shifter.
            if (bus.din_sof) begin
                cnt_nxt_s       = CNT_ONE;
                frame_err_nxt_s = (cnt_r != CNT_ZERO);
            end else if (cnt_r == CNT_LAST) begin
                cnt_nxt_s        = CNT_ZERO;
                dout_nxt_s       = word_s;
                dout_valid_nxt_s = 1'b1;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
        end else begin
            sr_nxt_s = sr_r;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r         <= {(N-1){1'b0}};
            cnt_r        <= CNT_ZERO;
            dout_r       <= {N{1'b0}};
            dout_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            sr_r         <= sr_nxt_s;
            cnt_r        <= cnt_nxt_s;
            dout_r       <= dout_nxt_s;
            dout_valid_r <= dout_valid_nxt_s;
            frame_err_r  <= frame_err_nxt_s;
        end
    end

    assign bus.din_ready  = ready_s;
    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.frame_err  = frame_err_r;
endmodule

// File: tb/tb_conv_s2p_lanes.sv
// Directed self-checking bench for conv_s2p_lanes: an MSB-first and an LSB-first
// instance receive identical stimulus and are compared against hand-computed words.
module tb_conv_s2p_lanes;
    logic clk = 1'b0;
    logic rst;
    logic din;
    logic din_valid;
    logic din_sof;
    logic dout_ready;

    int n_checks = 0;
    int n_errors = 0;
    int fe_cnt   = 0;
    int word_cnt = 0;

    always #5 clk = ~clk;

    conv_s2p_lanes_if #(.WIDTH(4), .LANES(4)) bus_msb ();
    conv_s2p_lanes_if #(.WIDTH(4), .LANES(4)) bus_lsb ();

    assign bus_msb.din        = din;
    assign bus_msb.din_valid  = din_valid;
    assign bus_msb.din_sof    = din_sof;
    assign bus_msb.dout_ready = dout_ready;
    assign bus_lsb.din        = din;
    assign bus_lsb.din_valid  = din_valid;
    assign bus_lsb.din_sof    = din_sof;
    assign bus_lsb.dout_ready = dout_ready;

    conv_s2p_lanes #(.WIDTH(4), .LANES(4), .MSB_FIRST(1)) dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus_msb)
    );

    conv_s2p_lanes #(.WIDTH(4), .LANES(4), .MSB_FIRST(0)) dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus_lsb)
    );

    // Count frame_err cycles and consumed words on the MSB-first instance
    always @(negedge clk) begin
        if (bus_msb.frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (bus_msb.dout_valid === 1'b1 && dout_ready === 1'b1) word_cnt <= word_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the bit is accepted.
    task automatic send_bit(input logic b, input logic sof);
        int guard = 0;
        din       = b;
        din_sof   = sof;
        din_valid = 1'b1;
        #1;
        while (bus_msb.din_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) check("din_ready_timeout", 16'(bus_msb.din_ready), 16'd1);
        @(negedge clk);
        din_valid = 1'b0;
        din_sof   = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input logic sof_first, input int max_gap);
        for (int i = 15; i >= 0; i--) begin
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            send_bit(w[i], sof_first && (i == 15));
        end
    endtask

    logic [15:0] w;
    logic [15:0] words [8];
    int fe0;
    int wc0;

    initial begin
        rst        = 1'b1;
        din        = 1'b0;
        din_valid  = 1'b0;
        din_sof    = 1'b0;
        dout_ready = 1'b1;
        words[0] = 16'h0001; words[1] = 16'h8000; words[2] = 16'hDEAD; words[3] = 16'h5A5A;
        words[4] = 16'hFFFF; words[5] = 16'h0000; words[6] = 16'h1357; words[7] = 16'hC0DE;
        repeat (2) @(negedge clk);
        check("rst_dout",       bus_msb.dout,              16'h0000);
        check("rst_dout_valid", 16'(bus_msb.dout_valid),   16'd0);
        check("rst_frame_err",  16'(bus_msb.frame_err),    16'd0);
        check("rst_din_ready",  16'(bus_msb.din_ready),    16'd1);
        rst = 1'b0;

        // Basic word, MSB-first and LSB-first views
        w = 16'hA5C3;
        for (int i = 15; i >= 1; i--) send_bit(w[i], i == 15);
        check("t1_no_early_valid", 16'(bus_msb.dout_valid), 16'd0);
        send_bit(w[0], 1'b0);
        check("t1_valid",  16'(bus_msb.dout_valid), 16'd1);
        check("t1_dout",   bus_msb.dout,            16'hA5C3);
        check("t1_lane3",  16'(bus_msb.dout[15:12]), 16'hA);
        check("t1_lane0",  16'(bus_msb.dout[3:0]),   16'h3);
        check("t2_lsb_dout", bus_lsb.dout,          16'hC3A5);

        // Backpressure: hold the first word, stall on the completing bit of the second
        dout_ready = 1'b0;
        w = 16'h1234;
        for (int i = 15; i >= 1; i--) send_bit(w[i], 1'b0);
        din       = w[0];
        din_valid = 1'b1;
        #1;
        check("t3_stall",        16'(bus_msb.din_ready),  16'd0);
        @(negedge clk);
        #1;
        check("t3_stall_hold",   16'(bus_msb.din_ready),  16'd0);
        check("t3_dout_held",    bus_msb.dout,            16'hA5C3);
        check("t3_valid_held",   16'(bus_msb.dout_valid), 16'd1);
        dout_ready = 1'b1;
        #1;
        check("t3_ready_back",   16'(bus_msb.din_ready),  16'd1);
        @(negedge clk);
        din_valid = 1'b0;
        check("t3_dout",         bus_msb.dout,            16'h1234);
        check("t3_valid_kept",   16'(bus_msb.dout_valid), 16'd1);
        check("t3_lsb_dout",     bus_lsb.dout,            16'h2C48);
        @(negedge clk);
        check("t3_drained",      16'(bus_msb.dout_valid), 16'd0);
        check("t3_dout_stable",  bus_msb.dout,            16'h1234);

        // Re-alignment after a 7-bit partial word
        repeat (2) @(negedge clk);
        fe0 = fe_cnt;
        wc0 = word_cnt;
        w = 16'hABCD;
        for (int i = 15; i >= 9; i--) send_bit(w[i], i == 15);
        w = 16'hFFFF;
        send_word(w, 1'b1, 0);
        check("t4_dout",  bus_msb.dout,            16'hFFFF);
        check("t4_valid", 16'(bus_msb.dout_valid), 16'd1);
        repeat (2) @(negedge clk);
        check("t4_frame_err_cycles", 16'(fe_cnt - fe0),   16'd1);
        check("t4_words",            16'(word_cnt - wc0), 16'd1);

        // Start-of-frame on the 16th bit discards instead of completing
        fe0 = fe_cnt;
        wc0 = word_cnt;
        w = 16'h1234;
        for (int i = 15; i >= 1; i--) send_bit(w[i], i == 15);
        w = 16'hBEEF;
        send_word(w, 1'b1, 0);
        check("t4b_dout", bus_msb.dout, 16'hBEEF);
        repeat (2) @(negedge clk);
        check("t4b_frame_err_cycles", 16'(fe_cnt - fe0),   16'd1);
        check("t4b_words",            16'(word_cnt - wc0), 16'd1);

        // Eight words with random input gaps
        fe0 = fe_cnt;
        wc0 = word_cnt;
        for (int k = 0; k < 8; k++) begin
            send_word(words[k], k == 0, 2);
            check($sformatf("t5_word%0d", k), bus_msb.dout, words[k]);
            check($sformatf("t5_valid%0d", k), 16'(bus_msb.dout_valid), 16'd1);
        end
        repeat (2) @(negedge clk);
        check("t5_no_frame_err", 16'(fe_cnt - fe0),   16'd0);
        check("t5_words",        16'(word_cnt - wc0), 16'd8);

        // Reset with a pending word and a 9-bit partial
        dout_ready = 1'b0;
        w = 16'h5555;
        send_word(w, 1'b1, 0);
        w = 16'h0F0F;
        for (int i = 15; i >= 7; i--) send_bit(w[i], 1'b0);
        check("t6_pre_valid", 16'(bus_msb.dout_valid), 16'd1);
        fe0 = fe_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_dout",  bus_msb.dout,            16'h0000);
        check("t6_rst_valid", 16'(bus_msb.dout_valid), 16'd0);
        check("t6_rst_ready", 16'(bus_msb.din_ready),  16'd1);
        check("t6_rst_fe",    16'(bus_msb.frame_err),  16'd0);
        rst        = 1'b0;
        dout_ready = 1'b1;
        w = 16'h6A3C;
        send_word(w, 1'b0, 0);
        check("t6_dout",     bus_msb.dout,            16'h6A3C);
        check("t6_valid",    16'(bus_msb.dout_valid), 16'd1);
        check("t6_lsb_dout", bus_lsb.dout,            16'h3C56);
        repeat (2) @(negedge clk);
        check("t6_no_frame_err", 16'(fe_cnt - fe0), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end
endmodule
